// File: rtl/sky_pkg.sv
// Shared constants for the falling-item playfield: screen geometry, colour
// encodings, slot state encodings and the item LFSR definition.
package sky_pkg;

  // Visible screen area and the default retirement line.
  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;
  localparam int DEFAULT_FLOOR_Y = 400;
  localparam int POS_W           = 10;

  // Item colours; NONE is reserved for empty slots.
  typedef enum logic [1:0] {
    COLOR_NONE = 2'b00,
    COLOR_C1   = 2'b01,
    COLOR_C2   = 2'b10,
    COLOR_C3   = 2'b11
  } color_e;

  // Per-slot state encodings.
  localparam logic [0:0] SLOT_IDLE    = 1'b0;
  localparam logic [0:0] SLOT_FALLING = 1'b1;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam int               LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One falling-item slot.
  typedef struct packed {
    logic [0:0]       state;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [2:0]       speed;
    logic [1:0]       color;
  } slot_t;

  // Next LFSR state: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/item_lfsr.sv
// Free-running pseudo-random source for item spawning; steps every clock.
module item_lfsr
  import sky_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] rnd
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next state is a pure function of the current register.
  always_comb begin
    state_d = lfsr_next(state_q);
  end

  // Reload the seed on reset, otherwise advance unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign rnd = state_q;

endmodule

// File: rtl/falling_item_pool.sv
// Pool of independent falling items: periodic random spawns into the lowest
// free slot, per-tick fall, floor misses and catch retirements.
module falling_item_pool
  import sky_pkg::*;
#(
  parameter int          NUM_ITEMS = 4,
  parameter int          FLOOR_Y   = DEFAULT_FLOOR_Y,
  parameter int          X_LIMIT   = 600,
  parameter int          MAX_SPEED = 4,
  parameter int          SPAWN_GAP = 50,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    pause,
  input  logic                    catch_valid,
  input  logic [2:0]              catch_idx,
  output logic [10*NUM_ITEMS-1:0] pos_x,
  output logic [10*NUM_ITEMS-1:0] pos_y,
  output logic [2*NUM_ITEMS-1:0]  color,
  output logic [NUM_ITEMS-1:0]    active,
  output logic                    caught,
  output logic                    missed,
  output logic [7:0]              miss_count
);

  localparam int               CNT_W    = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_GAP - 1);
  localparam logic [10:0]      FLOOR_W  = 11'(FLOOR_Y);
  localparam logic [10:0]      XLIM_W   = 11'(X_LIMIT);
  localparam logic [2:0]       SPD_MOD  = 3'(MAX_SPEED);

  logic [LFSR_W-1:0] rnd;

  item_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED),
    .rnd   (rnd)
  );

  // Motion and spawn timing only advance on an unpaused tick.
  logic step;
  assign step = tick & ~pause;

  logic [CNT_W-1:0]     spawn_cnt_q, spawn_cnt_d;
  logic                 spawn_try;
  logic [1:0]           color_rot_q, color_rot_d;
  logic                 caught_q, caught_d;
  logic                 missed_q, missed_d;
  logic [7:0]           miss_count_q, miss_count_d;

  logic [NUM_ITEMS-1:0] idle_vec;
  logic [NUM_ITEMS-1:0] catch_vec;
  logic [NUM_ITEMS-1:0] miss_vec;
  logic [NUM_ITEMS-1:0] spawn_sel;
  logic                 spawn_hit;

  logic [10:0]          raw_x;
  logic [9:0]           spawn_x;
  logic [2:0]           spawn_speed;
  logic [1:0]           spawn_color;
  logic                 use_rot;

  // Spawn interval counter: wraps at SPAWN_GAP-1 and fires one attempt.
  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    spawn_try   = 1'b0;
    if (step) begin
      if (spawn_cnt_q == CNT_LAST) begin
        spawn_cnt_d = '0;
        spawn_try   = 1'b1;
      end else begin
        spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
      end
    end
  end

  // Derive spawn attributes from the current LFSR word; x needs at most one
  // subtraction because X_LIMIT is at least half the 10-bit range.
  always_comb begin
    raw_x       = {1'b0, rnd[9:0]};
    spawn_x     = (raw_x >= XLIM_W) ? 10'(raw_x - XLIM_W) : rnd[9:0];
    spawn_speed = (rnd[12:10] % SPD_MOD) + 3'd1;
    use_rot     = (rnd[15:14] == COLOR_NONE);
    spawn_color = use_rot ? color_rot_q : rnd[15:14];
  end

  // Only slots idle before this edge are candidates, so slots freed by a catch
  // or a miss on the same edge wait for the next attempt; lowest index wins.
  always_comb begin
    spawn_sel = spawn_try ? (idle_vec & (~idle_vec + NUM_ITEMS'(1))) : '0;
    spawn_hit = |spawn_sel;
  end

  // Event pulses, saturating miss counter and the fallback colour rotation.
  always_comb begin
    caught_d     = |catch_vec;
    missed_d     = |miss_vec;
    miss_count_d = miss_count_q;
    if (missed_d && (miss_count_q != 8'hFF)) begin
      miss_count_d = miss_count_q + 8'd1;
    end
    color_rot_d = color_rot_q;
    if (spawn_hit && use_rot) begin
      color_rot_d = (color_rot_q == 2'b11) ? 2'b01 : color_rot_q + 2'b01;
    end
  end

  // Shared pool registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_cnt_q  <= '0;
      color_rot_q  <= 2'b01;
      caught_q     <= 1'b0;
      missed_q     <= 1'b0;
      miss_count_q <= 8'd0;
    end else begin
      spawn_cnt_q  <= spawn_cnt_d;
      color_rot_q  <= color_rot_d;
      caught_q     <= caught_d;
      missed_q     <= missed_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign caught     = caught_q;
  assign missed     = missed_q;
  assign miss_count = miss_count_q;

  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_slot
    slot_t       slot_q, slot_d;
    logic [10:0] sum;
    logic        is_falling;
    logic        hit;
    logic        floor_hit;

    assign is_falling = (slot_q.state == SLOT_FALLING);
    assign sum        = {1'b0, slot_q.y} + {8'd0, slot_q.speed};
    assign hit        = catch_valid && (catch_idx == 3'(gi)) && is_falling;
    // A catch on the same edge takes precedence over reaching the floor.
    assign floor_hit  = step && is_falling && !hit && (sum >= FLOOR_W);

    // Slot transition: retire on catch/floor, fall on step, load on spawn.
    always_comb begin
      slot_d = slot_q;
      if (hit || floor_hit) begin
        slot_d       = '0;
        slot_d.state = SLOT_IDLE;
      end else if (is_falling) begin
        if (step) begin
          slot_d.y = sum[9:0];
        end
      end else if (spawn_sel[gi]) begin
        slot_d.state = SLOT_FALLING;
        slot_d.x     = spawn_x;
        slot_d.y     = '0;
        slot_d.speed = spawn_speed;
        slot_d.color = spawn_color;
      end
    end

    // Slot register; an empty slot reads back as all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign idle_vec[gi]          = ~is_falling;
    assign catch_vec[gi]         = hit;
    assign miss_vec[gi]          = floor_hit;
    assign active[gi]            = is_falling;
    assign pos_x[10*gi +: 10]    = slot_q.x;
    assign pos_y[10*gi +: 10]    = slot_q.y;
    assign color[2*gi +: 2]      = slot_q.color;
  end

endmodule

// File: tb/tb_falling_item_pool.sv
// Directed bench for falling_item_pool: a four-slot instance exercised through
// spawn, fill-up, catch, pause, floor misses, saturation and mid-run reset,
// plus a one-slot instance that spawns every other clock to cover x folding
// and the colour rotation.
module tb_falling_item_pool;

  localparam int          N     = 4;
  localparam int          FLOOR = 400;
  localparam int          XLIM  = 600;
  localparam int          MAXS  = 4;
  localparam int          GAP   = 4;
  localparam logic [15:0] SEED1 = 16'hACE1;
  localparam int          XLIM2 = 512;
  localparam int          MAXS2 = 7;
  localparam logic [15:0] SEED2 = 16'h1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1
  logic              rst_n, tick, pause, catch_valid;
  logic [2:0]        catch_idx;
  logic [10*N-1:0]   pos_x, pos_y;
  logic [2*N-1:0]    color;
  logic [N-1:0]      active;
  logic              caught, missed;
  logic [7:0]        miss_count;

  // Instance 2
  logic              rst2_n, tick2, pause2, cv2;
  logic [2:0]        idx2;
  logic [9:0]        x2, y2;
  logic [1:0]        col2;
  logic [0:0]        act2;
  logic              caught2, missed2;
  logic [7:0]        mc2;

  falling_item_pool #(
    .NUM_ITEMS(N), .FLOOR_Y(FLOOR), .X_LIMIT(XLIM), .MAX_SPEED(MAXS),
    .SPAWN_GAP(GAP), .SEED(SEED1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pause(pause),
    .catch_valid(catch_valid), .catch_idx(catch_idx),
    .pos_x(pos_x), .pos_y(pos_y), .color(color), .active(active),
    .caught(caught), .missed(missed), .miss_count(miss_count)
  );

  falling_item_pool #(
    .NUM_ITEMS(1), .FLOOR_Y(FLOOR), .X_LIMIT(XLIM2), .MAX_SPEED(MAXS2),
    .SPAWN_GAP(1), .SEED(SEED2)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .tick(tick2), .pause(pause2),
    .catch_valid(cv2), .catch_idx(idx2),
    .pos_x(x2), .pos_y(y2), .color(col2), .active(act2),
    .caught(caught2), .missed(missed2), .miss_count(mc2)
  );

  int check_cnt = 0;
  int error_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected state of instance 1
  bit          e_act[N];
  int          e_x[N], e_y[N], e_spd[N], e_col[N];
  int          e_cnt, e_rot, e_mc;
  bit          e_caught, e_missed;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      e_act[i] = 0; e_x[i] = 0; e_y[i] = 0; e_spd[i] = 0; e_col[i] = 0;
    end
    e_cnt = 0; e_rot = 1; e_mc = 0; e_caught = 0; e_missed = 0;
    m_lfsr = SEED1;
  endtask

  // Predict the effect of one clock edge with the given inputs.
  task automatic model_edge(input bit tk, input bit ps, input bit cv, input int ci);
    bit step, att, hit, any_miss;
    int sidx, c;
    step = tk && !ps;
    hit  = 0;
    if (cv && ci >= 0 && ci < N) hit = e_act[ci];
    att = 0;
    if (step) begin
      if (e_cnt == GAP - 1) begin e_cnt = 0; att = 1; end
      else e_cnt++;
    end
    sidx = -1;
    for (int i = N - 1; i >= 0; i--) if (!e_act[i]) sidx = i;
    any_miss = 0;
    for (int i = 0; i < N; i++) begin
      if (e_act[i]) begin
        if (hit && ci == i) begin
          e_act[i] = 0; e_x[i] = 0; e_y[i] = 0; e_spd[i] = 0; e_col[i] = 0;
        end else if (step) begin
          if (e_y[i] + e_spd[i] >= FLOOR) begin
            e_act[i] = 0; e_x[i] = 0; e_y[i] = 0; e_spd[i] = 0; e_col[i] = 0;
            any_miss = 1;
          end else begin
            e_y[i] = e_y[i] + e_spd[i];
          end
        end
      end
    end
    if (att && sidx >= 0) begin
      e_act[sidx] = 1;
      e_x[sidx]   = int'(m_lfsr[9:0]);
      if (e_x[sidx] >= XLIM) e_x[sidx] = e_x[sidx] - XLIM;
      e_y[sidx]   = 0;
      e_spd[sidx] = (int'(m_lfsr[12:10]) % MAXS) + 1;
      c = int'(m_lfsr[15:14]);
      if (c == 0) begin
        c = e_rot;
        e_rot = (e_rot == 3) ? 1 : e_rot + 1;
      end
      e_col[sidx] = c;
    end
    e_caught = hit;
    e_missed = any_miss;
    if (any_miss && e_mc < 255) e_mc++;
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic compare_all(input string tag);
    logic [10*N-1:0] ex, ey;
    logic [2*N-1:0]  ec;
    logic [N-1:0]    ea;
    for (int i = 0; i < N; i++) begin
      ex[10*i +: 10] = 10'(e_x[i]);
      ey[10*i +: 10] = 10'(e_y[i]);
      ec[2*i +: 2]   = 2'(e_col[i]);
      ea[i]          = e_act[i];
    end
    check({tag, "_active"}, 64'(active), 64'(ea));
    check({tag, "_pos_x"}, 64'(pos_x), 64'(ex));
    check({tag, "_pos_y"}, 64'(pos_y), 64'(ey));
    check({tag, "_color"}, 64'(color), 64'(ec));
    check({tag, "_caught"}, 64'(caught), 64'(e_caught));
    check({tag, "_missed"}, 64'(missed), 64'(e_missed));
    check({tag, "_miss_count"}, 64'(miss_count), 64'(e_mc));
  endtask

  task automatic cycle(input string tag, input bit tk, input bit ps, input bit cv, input int ci);
    tick = tk; pause = ps; catch_valid = cv; catch_idx = 3'(ci);
    model_edge(tk, ps, cv, ci);
    @(posedge clk); #1;
    tick = 1'b0; pause = 1'b0; catch_valid = 1'b0; catch_idx = 3'd0;
    compare_all(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          iter;
    bit          first_miss_seen, catch_done;
    int          sx, scol, rot2, zero_draws;
    bit          a2;
    logic [15:0] m2;

    rst_n = 1'b0; tick = 1'b0; pause = 1'b0; catch_valid = 1'b0; catch_idx = 3'd0;
    rst2_n = 1'b0; tick2 = 1'b0; pause2 = 1'b0; cv2 = 1'b0; idx2 = 3'd0;
    model_reset();
    #12;
    compare_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Catch on an idle slot is ignored.
    cycle("idle_catch", 0, 0, 1, 0);
    check("idle_catch_nopulse", 64'(caught), 64'd0);

    // First spawn after GAP ticks.
    for (int k = 0; k < GAP - 1; k++) cycle("warm", 1, 0, 0, 0);
    check("s1_none_yet", 64'(active), 64'd0);
    cycle("s1", 1, 0, 0, 0);
    check("s1_slot0_active", 64'(active), 64'h1);
    check("s1_slot0_y", 64'(pos_y[9:0]), 64'd0);
    check("s1_slot0_xlim", 64'(pos_x[9:0] < 10'(XLIM)), 64'd1);
    check("s1_slot0_color", 64'(color[1:0] != 2'b00), 64'd1);

    // Fill all slots (ticks 5..16), then one attempt with the pool full.
    for (int k = 0; k < 3 * GAP; k++) cycle("fill", 1, 0, 0, 0);
    check("fill_all", 64'(active), 64'hF);
    for (int k = 0; k < GAP; k++) cycle("full_attempt", 1, 0, 0, 0);
    check("full_drop", 64'(active), 64'hF);

    // Out-of-range catch ignored; catch slot 2; the next attempt refills it.
    cycle("oor_catch", 0, 0, 1, 5);
    check("oor_catch_nopulse", 64'(caught), 64'd0);
    cycle("catch2", 0, 0, 1, 2);
    check("catch2_pulse", 64'(caught), 64'd1);
    check("catch2_active", 64'(active), 64'hB);
    for (int k = 0; k < GAP - 1; k++) cycle("refill_wait", 1, 0, 0, 0);
    check("refill_not_yet", 64'(active), 64'hB);
    cycle("refill", 1, 0, 0, 0);
    check("refill_active", 64'(active), 64'hF);
    check("refill_slot2_y", 64'(pos_y[29:20]), 64'd0);

    // Pause for 20 ticks with a catch in the middle; y and timing hold.
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        cycle("pause_catch", 1, 1, 1, 3);
        check("pause_catch_pulse", 64'(caught), 64'd1);
      end else begin
        cycle("pause", 1, 1, 0, 0);
      end
    end
    check("pause_active", 64'(active), 64'h7);
    for (int k = 0; k < GAP - 1; k++) cycle("resume", 1, 0, 0, 0);
    check("resume_not_yet", 64'(active), 64'h7);
    cycle("resume_spawn", 1, 0, 0, 0);
    check("resume_spawn_active", 64'(active), 64'hF);

    // Run to the floor: first miss, and a catch on slot 1 on its floor edge.
    first_miss_seen = 0;
    catch_done      = 0;
    iter            = 0;
    while ((!first_miss_seen || !catch_done) && iter < 800) begin
      if (!catch_done && e_act[1] && (e_y[1] + e_spd[1] >= FLOOR)) begin
        cycle("floor_catch", 1, 0, 1, 1);
        check("floor_catch_caught", 64'(caught), 64'd1);
        check("floor_catch_slot1_idle", 64'(active[1]), 64'd0);
        catch_done = 1;
      end else begin
        cycle("fall", 1, 0, 0, 0);
        if (e_missed && !first_miss_seen) begin
          check("first_miss_pulse", 64'(missed), 64'd1);
          check("first_miss_count", 64'(miss_count), 64'd1);
          first_miss_seen = 1;
          cycle("miss_gap", 0, 0, 0, 0);
          check("miss_single_pulse", 64'(missed), 64'd0);
        end
      end
      iter++;
    end
    check("floor_events_reached", 64'(first_miss_seen && catch_done), 64'd1);

    // Saturate the miss counter.
    iter = 0;
    while (e_mc < 255 && iter < 25000) begin
      cycle("sat", 1, 0, 0, 0);
      iter++;
    end
    for (int k = 0; k < 400; k++) cycle("sat_hold", 1, 0, 0, 0);
    check("miss_count_saturated", 64'(miss_count), 64'd255);

    // Asynchronous reset mid-fall.
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < GAP - 1; k++) cycle("post_reset", 1, 0, 0, 0);
    check("post_reset_none", 64'(active), 64'd0);
    cycle("post_reset_spawn", 1, 0, 0, 0);
    check("post_reset_spawn_active", 64'(active), 64'h1);

    // Instance 2: spawn/catch alternating, covering x folding and colour rotation.
    @(posedge clk); #1;
    rst2_n = 1'b1;
    m2 = SEED2; rot2 = 1; a2 = 0; zero_draws = 0;
    for (int k = 0; k < 2000; k++) begin
      tick2 = 1'b1; cv2 = a2; idx2 = 3'd0;
      @(posedge clk); #1;
      if (!a2) begin
        sx = int'(m2[9:0]);
        if (sx >= XLIM2) sx = sx - XLIM2;
        scol = int'(m2[15:14]);
        if (scol == 0) begin
          zero_draws++;
          scol = rot2;
          rot2 = (rot2 == 3) ? 1 : rot2 + 1;
        end
        if (k == 0) begin
          check("d2_first_x", 64'(x2), 64'd52);
          check("d2_first_color", 64'(col2), 64'd1);
        end
        check("d2_active", 64'(act2), 64'd1);
        check("d2_x", 64'(x2), 64'(sx));
        check("d2_xlim", 64'(x2 < 10'(XLIM2)), 64'd1);
        check("d2_y", 64'(y2), 64'd0);
        check("d2_color", 64'(col2), 64'(scol));
        a2 = 1;
      end else begin
        check("d2_caught", 64'(caught2), 64'd1);
        check("d2_idle", 64'(act2), 64'd0);
        check("d2_color_idle", 64'(col2), 64'd0);
        a2 = 0;
      end
      check("d2_missed", 64'(missed2), 64'd0);
      m2 = lfsr_adv(m2);
    end
    tick2 = 1'b0; cv2 = 1'b0;
    check("d2_zero_draws_seen", 64'(zero_draws > 0), 64'd1);
    check("d2_miss_count", 64'(mc2), 64'd0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
